// File: rtl/sparc_iter_divider.sv
// Iterative radix-2 restoring divider for SPARC V8 UDIV/SDIV/UDIVCC/SDIVCC.
// 64/32 divide with V8 saturation, divide-by-zero trap and per-thread kill.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// CHECK | form magnitudes, detect divide-by-zero and early overflow
// ITER  | one restoring quotient bit per cycle, 32 cycles
// FIX   | apply sign and saturation, load response registers
// DONE  | response held until resp_ready
module sparc_iter_divider #(
  parameter int          TID_W     = 6,
  parameter logic [5:0]  TT_DIVZ_V = 6'b101010
) (
  input  logic             gclk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_op3,
  input  logic [TID_W-1:0] req_tid,
  input  logic [31:0]      req_y,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic             kill_valid,
  input  logic [TID_W-1:0] kill_tid,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [TID_W-1:0] resp_tid,
  output logic [31:0]      resp_result,
  output logic             resp_icc_we,
  output logic [3:0]       resp_icc,
  output logic             resp_trap,
  output logic [5:0]       resp_tt
);

  typedef enum logic [2:0] {IDLE, CHECK, ITER, FIX, DONE} state_t;

  state_t           state;
  logic             cc_q, sgn_q, qneg_q, trap_q, ovf_q;
  logic [TID_W-1:0] tid_q;
  logic [31:0]      y_q, rs1_q, rs2_q;
  logic [31:0]      dvs_q, rem_q, quo_q;
  logic [4:0]       cnt_q;

  // only the CC and signed bits of op3 steer the datapath
  logic unused_op3;
  assign unused_op3 = ^{req_op3[5], req_op3[3:1]};

  assign req_ready = (state == IDLE);

  logic kill_hit;
  assign kill_hit = kill_valid && (state != IDLE) && (kill_tid == tid_q);

  // CHECK: operand magnitudes
  logic        dvd_neg, dvs_neg, div_zero, early_ovf;
  logic [63:0] dvd, dvd_mag;
  logic [31:0] dvs_mag;

  always_comb begin
    dvd       = {y_q, rs1_q};
    dvd_neg   = sgn_q & y_q[31];
    dvs_neg   = sgn_q & rs2_q[31];
    dvd_mag   = dvd_neg ? (64'd0 - dvd) : dvd;
    dvs_mag   = dvs_neg ? (32'd0 - rs2_q) : rs2_q;
    div_zero  = (rs2_q == 32'd0);
    early_ovf = !div_zero && (dvd_mag[63:32] >= dvs_mag);
  end

  // ITER: quo_q shifts dividend bits out the top and quotient bits in the bottom
  logic [32:0] rem_sh, rem_sub;
  logic        qbit;

  always_comb begin
    rem_sh  = {rem_q, quo_q[31]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    qbit    = (rem_sh >= {1'b0, dvs_q});
  end

  // FIX: sign and saturation
  logic [31:0] fix_res;
  logic        fix_v;

  always_comb begin
    fix_res = quo_q;
    fix_v   = 1'b0;
    if (trap_q) begin
      fix_res = 32'd0;
    end else if (ovf_q) begin
      fix_v   = 1'b1;
      fix_res = !sgn_q ? 32'hFFFF_FFFF : (qneg_q ? 32'h8000_0000 : 32'h7FFF_FFFF);
    end else if (sgn_q && !qneg_q) begin
      if (quo_q > 32'h7FFF_FFFF) begin
        fix_res = 32'h7FFF_FFFF;
        fix_v   = 1'b1;
      end
    end else if (sgn_q && qneg_q) begin
      if (quo_q > 32'h8000_0000) begin
        fix_res = 32'h8000_0000;
        fix_v   = 1'b1;
      end else begin
        fix_res = 32'd0 - quo_q;
      end
    end
  end

  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cc_q        <= 1'b0;
      sgn_q       <= 1'b0;
      qneg_q      <= 1'b0;
      trap_q      <= 1'b0;
      ovf_q       <= 1'b0;
      tid_q       <= '0;
      y_q         <= 32'd0;
      rs1_q       <= 32'd0;
      rs2_q       <= 32'd0;
      dvs_q       <= 32'd0;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      cnt_q       <= 5'd0;
      resp_valid  <= 1'b0;
      resp_tid    <= '0;
      resp_result <= 32'd0;
      resp_icc_we <= 1'b0;
      resp_icc    <= 4'd0;
      resp_trap   <= 1'b0;
      resp_tt     <= 6'd0;
    end else if (kill_hit) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cc_q  <= req_op3[4];
            sgn_q <= req_op3[0];
            tid_q <= req_tid;
            y_q   <= req_y;
            rs1_q <= req_rs1;
            rs2_q <= req_rs2;
            state <= CHECK;
          end
        end
        CHECK: begin
          qneg_q <= dvd_neg ^ dvs_neg;
          dvs_q  <= dvs_mag;
          rem_q  <= dvd_mag[63:32];
          quo_q  <= dvd_mag[31:0];
          cnt_q  <= 5'd31;
          trap_q <= div_zero;
          ovf_q  <= early_ovf;
          // early exits still pass through FIX so the response appears after edge 2
          state  <= (div_zero || early_ovf) ? FIX : ITER;
        end
        ITER: begin
          rem_q <= qbit ? rem_sub[31:0] : rem_sh[31:0];
          quo_q <= {quo_q[30:0], qbit};
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) state <= FIX;
        end
        FIX: begin
          resp_valid  <= 1'b1;
          resp_tid    <= tid_q;
          resp_result <= fix_res;
          resp_icc_we <= cc_q & ~trap_q;
          resp_icc    <= {fix_res[31], (fix_res == 32'd0), fix_v, 1'b0};
          resp_trap   <= trap_q;
          resp_tt     <= trap_q ? TT_DIVZ_V : 6'd0;
          state       <= DONE;
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sparc_iter_divider.sv
// Scoreboard bench for sparc_iter_divider: directed V8 cases, kills,
// response back-pressure and a batch of random divides.
module tb_sparc_iter_divider;

  localparam int TID_W = 6;

  logic             gclk = 1'b0;
  logic             rstn;
  logic             req_valid;
  logic             req_ready;
  logic [5:0]       req_op3;
  logic [TID_W-1:0] req_tid;
  logic [31:0]      req_y, req_rs1, req_rs2;
  logic             kill_valid;
  logic [TID_W-1:0] kill_tid;
  logic             resp_valid;
  logic             resp_ready;
  logic [TID_W-1:0] resp_tid;
  logic [31:0]      resp_result;
  logic             resp_icc_we;
  logic [3:0]       resp_icc;
  logic             resp_trap;
  logic [5:0]       resp_tt;

  localparam logic [5:0] UDIV = 6'b001110, SDIV = 6'b001111,
                         UDIVCC = 6'b011110, SDIVCC = 6'b011111;

  sparc_iter_divider #(.TID_W(TID_W), .TT_DIVZ_V(6'b101010)) dut (
    .gclk(gclk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op3(req_op3),
    .req_tid(req_tid), .req_y(req_y), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .kill_valid(kill_valid), .kill_tid(kill_tid),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tid(resp_tid),
    .resp_result(resp_result), .resp_icc_we(resp_icc_we), .resp_icc(resp_icc),
    .resp_trap(resp_trap), .resp_tt(resp_tt)
  );

  always #5 gclk = ~gclk;

  typedef struct {
    logic [TID_W-1:0] tid;
    logic [31:0]      res;
    logic             icc_we;
    logic [3:0]       icc;
    logic             trap;
    logic [5:0]       tt;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [5:0] op3, input logic [TID_W-1:0] tid,
                                 input logic [31:0] y, input logic [31:0] rs1,
                                 input logic [31:0] rs2);
    exp_t        e;
    logic        v;
    logic [63:0] uq;
    longint      a, b, q;
    e.tid  = tid;
    e.trap = (rs2 == 32'd0);
    e.tt   = e.trap ? 6'b101010 : 6'd0;
    e.res  = 32'd0;
    e.lat  = 34;
    v      = 1'b0;
    if (e.trap) begin
      e.lat = 2;
    end else if (!op3[0]) begin
      uq = {y, rs1} / {32'd0, rs2};
      if (uq[63:32] != 32'd0) begin
        e.res = 32'hFFFF_FFFF; v = 1'b1; e.lat = 2;
      end else begin
        e.res = uq[31:0];
      end
    end else begin
      a = {y, rs1};
      b = $signed(rs2);
      q = a / b;
      if (q >= 64'sh1_0000_0000 || q <= -64'sh1_0000_0000) e.lat = 2;
      if (q > 64'sh7FFF_FFFF) begin
        e.res = 32'h7FFF_FFFF; v = 1'b1;
      end else if (q < -64'sh8000_0000) begin
        e.res = 32'h8000_0000; v = 1'b1;
      end else begin
        e.res = q[31:0];
      end
    end
    e.icc    = {e.res[31], (e.res == 32'd0), v, 1'b0};
    e.icc_we = op3[4] & ~e.trap;
    return e;
  endfunction

  task automatic issue(input logic [5:0] op3, input logic [TID_W-1:0] tid,
                       input logic [31:0] y, input logic [31:0] rs1, input logic [31:0] rs2);
    int w = 0;
    while (!req_ready && w < 100) begin @(posedge gclk); #1; w++; end
    chk("issue_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_op3 = op3; req_tid = tid;
    req_y = y; req_rs1 = rs1; req_rs2 = rs2;
    @(posedge gclk); #1;
    req_valid = 1'b0;
  endtask

  // issue one op, track latency, hold resp_ready low for 'hold' cycles, then handshake
  task automatic do_op(input string tag, input logic [5:0] op3, input logic [TID_W-1:0] tid,
                       input logic [31:0] y, input logic [31:0] rs1, input logic [31:0] rs2,
                       input int hold);
    exp_t e;
    int   lat = 0;
    sb.push_back(model(op3, tid, y, rs1, rs2));
    issue(op3, tid, y, rs1, rs2);
    while (!resp_valid && lat < 100) begin @(posedge gclk); #1; lat++; end
    e = sb.pop_front();
    chk({tag, "_lat"}, lat, e.lat);
    chk({tag, "_tid"}, resp_tid, e.tid);
    chk({tag, "_trap"}, resp_trap, e.trap);
    chk({tag, "_tt"}, resp_tt, e.tt);
    chk({tag, "_iccwe"}, resp_icc_we, e.icc_we);
    if (!e.trap) begin
      chk({tag, "_res"}, resp_result, e.res);
      chk({tag, "_icc"}, resp_icc, e.icc);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge gclk); #1;
      chk({tag, "_hold_valid"}, resp_valid, 1'b1);
      chk({tag, "_hold_res"}, {resp_result, resp_icc, resp_tid}, {e.trap ? resp_result : e.res,
          e.trap ? resp_icc : e.icc, e.tid});
    end
    resp_ready = 1'b1;
    @(posedge gclk); #1;
    resp_ready = 1'b0;
    chk({tag, "_released"}, resp_valid, 1'b0);
    chk({tag, "_idle"}, req_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int seen;
    logic [31:0] ry, r1, r2;
    logic [5:0]  rop;
    rstn = 1'b0; req_valid = 1'b0; req_op3 = 6'd0; req_tid = '0;
    req_y = 32'd0; req_rs1 = 32'd0; req_rs2 = 32'd0;
    kill_valid = 1'b0; kill_tid = '0; resp_ready = 1'b0;
    repeat (3) @(posedge gclk);
    #1;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_valid", resp_valid, 1'b0);
    chk("rst_resp", {resp_result, resp_icc, resp_trap, resp_tt, resp_icc_we}, 0);
    rstn = 1'b1;
    @(posedge gclk); #1;

    do_op("udiv",     UDIV,   6'd1, 32'h0,        32'd100,      32'd7, 0);
    do_op("sdivcc",   SDIVCC, 6'd2, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'd7, 0);
    do_op("udivcc_ov", UDIVCC, 6'd3, 32'h1,       32'h0,        32'd1, 0);
    do_op("sdiv_ov",  SDIV,   6'd4, 32'h0,        32'h8000_0000, 32'd1, 0);
    do_op("sdiv_z",   SDIV,   6'd5, 32'h1234,     32'h5678,     32'd0, 0);
    do_op("sdivcc_min", SDIVCC, 6'd6, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 0);
    do_op("sdiv_nm",  SDIVCC, 6'd7, 32'h0,        32'd50,       32'h8000_0000, 0);
    do_op("udivcc_z", UDIVCC, 6'd8, 32'h0,        32'd0,        32'd9, 0);
    do_op("hold",     UDIVCC, 6'd9, 32'h0,        32'hDEAD_BEEF, 32'd3, 10);

    // kill: non-matching tid ignored, matching tid squashes
    issue(UDIV, 6'd5, 32'h0, 32'd1000, 32'd3);
    repeat (5) @(posedge gclk);
    #1;
    kill_valid = 1'b1; kill_tid = 6'd3;
    @(posedge gclk); #1;
    chk("kill_other_busy", req_ready, 1'b0);
    kill_tid = 6'd5;
    @(posedge gclk); #1;
    kill_valid = 1'b0;
    chk("kill_ready", req_ready, 1'b1);
    chk("kill_novalid", resp_valid, 1'b0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge gclk); #1;
      if (resp_valid) seen++;
    end
    chk("kill_noresp", seen, 0);
    kill_valid = 1'b1; kill_tid = 6'd0;
    @(posedge gclk); #1;
    kill_valid = 1'b0;
    chk("kill_idle_ready", req_ready, 1'b1);

    // a kill from another thread during an op does not disturb it
    sb.push_back(model(SDIVCC, 6'd10, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'd17));
    issue(SDIVCC, 6'd10, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'd17);
    kill_valid = 1'b1; kill_tid = 6'd11;
    @(posedge gclk); #1;
    kill_valid = 1'b0;
    seen = 0;
    while (!resp_valid && seen < 100) begin @(posedge gclk); #1; seen++; end
    begin
      exp_t e;
      e = sb.pop_front();
      chk("kill_miss_res", resp_result, e.res);
      chk("kill_miss_tid", resp_tid, e.tid);
    end
    resp_ready = 1'b1;
    @(posedge gclk); #1;
    resp_ready = 1'b0;

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: rop = UDIV;
        1: rop = SDIV;
        2: rop = UDIVCC;
        default: rop = SDIVCC;
      endcase
      r1 = $urandom;
      r2 = (n % 4 == 0) ? ($urandom & 32'hFF) : $urandom;
      case (n % 3)
        0: ry = 32'd0;
        1: ry = {32{r1[31]}};
        default: ry = $urandom & 32'h0000_FFFF;
      endcase
      if (r2 == 32'hFFFF_FFFF && ry == 32'h8000_0000) r2 = 32'd5;
      do_op("rand", rop, 6'(n), ry, r1, r2, n % 2);
    end

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
